mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, number of consecutive LSB grants allowed while a fetch waits.
REQ-002 clk_in  input  1  system clock; all state updates on rising edge.
REQ-003 rst_in  input  1  reset, synchronous, active-high.
REQ-004 rdy_in  input  1  global enable; low freezes all state and outputs.
REQ-005 flush_in  input  1  branch mispredict; cancels fetch traffic only.
REQ-006 if_req / if_addr  input  1/32  icache fetch request and word address.
REQ-007 if_ack  output  1  one-cycle pulse: fetch request accepted (latched).
REQ-008 if_done / if_data  output  1/32  one-cycle pulse with fetched instruction word.
REQ-009 ls_req / ls_store / ls_addr / ls_data / ls_op  input  1/1/32/32/3  LSB access; ls_op = funct3.
REQ-010 ls_ack  output  1  one-cycle pulse: LSB request accepted.
REQ-011 ls_done / ls_rdata  output  1/32  one-cycle pulse with load result (0 for stores).
REQ-012 mc_fetch / mc_fetch_addr  output  1/32  fetch request to memory controller.
REQ-013 mc_io / mc_store / mc_addr / mc_data / mc_op  output  1/1/32/32/3  load/store request to memory controller.
REQ-014 mc_working  input  1  memory controller busy.
REQ-015 mc_back / mc_back_ins  input  1/32  fetch completion and word.
REQ-016 mc_res_avail / mc_res  input  1/32  load/store completion and extended load data.

Function
REQ-017 States: IDLE, ISSUE, WAIT, DROP; one 2-bit owner register: NONE, IF, LS.
REQ-018 Requests latched into a one-entry slot per requester; if_ack/ls_ack pulse the cycle after a slot fills; requester must drop req after ack.
REQ-019 IDLE with any slot full: grant, drive mc_* from slot, go ISSUE same edge.
REQ-020 Priority: LS over IF, except IF wins when starve counter >= STARVE_LIMIT and IF slot full.
REQ-021 Starve counter: 3 bits, +1 per LS grant while IF slot full, saturates at 7, cleared on IF grant or IF slot empty.
REQ-022 ISSUE: hold mc_fetch or mc_io high with stable address/data/op until mc_working sampled 1, then deassert request, go WAIT.
REQ-023 mc_op, mc_addr, mc_store held stable through WAIT (controller extends load data combinationally from mc_op).
REQ-024 WAIT, owner IF: on mc_back, register mc_back_ins into if_data, pulse if_done next cycle, free IF slot, go IDLE.
REQ-025 WAIT, owner LS: on mc_res_avail, register mc_res (0 if store) into ls_rdata, pulse ls_done next cycle, free LS slot, go IDLE.
REQ-026 Completion-to-done latency exactly 1 cycle; a new grant may issue on the cycle after completion.
REQ-027 flush_in: IF slot cleared same edge; if owner IF in ISSUE or WAIT, go DROP (ISSUE with mc_working still 0: deassert mc_fetch, go IDLE).
REQ-028 DROP: wait for mc_back, discard data, no if_done, go IDLE.
REQ-029 flush_in never affects LS slot or LS transaction.
REQ-030 if_req coincident with flush_in: request discarded, no if_ack.
REQ-031 Simultaneous if_req and ls_req in IDLE with empty slots: both acked, LS granted first.
REQ-032 Only one of mc_fetch, mc_io ever high in any cycle.
REQ-033 rdy_in low: no state, counter or slot change; pulses not re-emitted.

Reset
REQ-034 On rst_in: state IDLE, owner NONE, slots empty, starve counter 0.
REQ-035 On rst_in: all outputs 0 (acks, dones, data, mc_* request, address, data, op).
REQ-036 Reset mid-transaction abandons it with no done pulse; memory controller reset concurrently.

Verification
REQ-037 Fetch 0x00001000, controller returns 0x00A00093 -> if_done pulse with if_data=0x00A00093 one cycle after mc_back.
REQ-038 Simultaneous ls_req load lb addr 0x20 (mem 0x80) and if_req -> LS first, ls_rdata=0xFFFFFF80, then fetch issued.
REQ-039 IF pending, 6 back-to-back LS requests, STARVE_LIMIT=4 -> fetch granted after 4th LS completion.
REQ-040 flush_in during fetch WAIT -> mc_back ignored, no if_done, next LS store sw 0x12345678 completes with ls_done, ls_rdata=0.
REQ-041 rdy_in low 3 cycles during WAIT -> mc_* outputs held, completion handled after rdy_in returns high.
REQ-042 rst_in during LS WAIT -> next cycle all outputs 0, state IDLE, new fetch serviced normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates icache fetches and LSB loads/stores onto one memory controller port.
// Each requester has a one-entry slot; LS has priority unless a waiting fetch has starved.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_store,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_data,
  input  logic [2:0]  ls_op,
  output logic        ls_ack,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  output logic        mc_fetch,
  output logic [31:0] mc_fetch_addr,
  output logic        mc_io,
  output logic        mc_store,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_data,
  output logic [2:0]  mc_op,
  input  logic        mc_working,
  input  logic        mc_back,
  input  logic [31:0] mc_back_ins,
  input  logic        mc_res_avail,
  input  logic [31:0] mc_res
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DROP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_t;

  localparam int unsigned LIMIT = STARVE_LIMIT;

  state_t      state, state_d;
  owner_t      owner, owner_d;
  logic [2:0]  starve, starve_d;
  logic        if_valid, if_valid_d;
  logic [31:0] if_slot_addr, if_slot_addr_d;
  logic        ls_valid, ls_valid_d;
  logic        ls_slot_store, ls_slot_store_d;
  logic [31:0] ls_slot_addr, ls_slot_addr_d;
  logic [31:0] ls_slot_data, ls_slot_data_d;
  logic [2:0]  ls_slot_op, ls_slot_op_d;

  logic        if_ack_d, if_done_d, ls_ack_d, ls_done_d;
  logic [31:0] if_data_d, ls_rdata_d;
  logic        mc_fetch_d, mc_io_d, mc_store_d;
  logic [31:0] mc_fetch_addr_d, mc_addr_d, mc_data_d;
  logic [2:0]  mc_op_d;

  logic        if_avail, if_free, ls_free, grant_if, grant_ls;

  always_comb begin
    state_d         = state;
    owner_d         = owner;
    starve_d        = starve;
    if_valid_d      = if_valid;
    if_slot_addr_d  = if_slot_addr;
    ls_valid_d      = ls_valid;
    ls_slot_store_d = ls_slot_store;
    ls_slot_addr_d  = ls_slot_addr;
    ls_slot_data_d  = ls_slot_data;
    ls_slot_op_d    = ls_slot_op;
    if_ack_d        = 1'b0;
    if_done_d       = 1'b0;
    ls_ack_d        = 1'b0;
    ls_done_d       = 1'b0;
    if_data_d       = if_data;
    ls_rdata_d      = ls_rdata;
    mc_fetch_d      = mc_fetch;
    mc_fetch_addr_d = mc_fetch_addr;
    mc_io_d         = mc_io;
    mc_store_d      = mc_store;
    mc_addr_d       = mc_addr;
    mc_data_d       = mc_data;
    mc_op_d         = mc_op;
    if_free         = 1'b0;
    ls_free         = 1'b0;
    grant_if        = 1'b0;
    grant_ls        = 1'b0;
    if_avail        = if_valid && !flush_in;

    case (state)
      IDLE: begin
        if (ls_valid && !(if_avail && (32'(starve) >= LIMIT))) begin
          grant_ls   = 1'b1;
          mc_io_d    = 1'b1;
          mc_store_d = ls_slot_store;
          mc_addr_d  = ls_slot_addr;
          mc_data_d  = ls_slot_data;
          mc_op_d    = ls_slot_op;
          owner_d    = OWN_LS;
          state_d    = ISSUE;
        end else if (if_avail) begin
          grant_if        = 1'b1;
          mc_fetch_d      = 1'b1;
          mc_fetch_addr_d = if_slot_addr;
          owner_d         = OWN_IF;
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        // A flushed fetch the controller never took can simply be withdrawn.
        if (owner == OWN_IF && flush_in) begin
          mc_fetch_d = 1'b0;
          state_d    = mc_working ? DROP : IDLE;
          owner_d    = mc_working ? OWN_IF : OWN_NONE;
        end else if (mc_working) begin
          mc_fetch_d = 1'b0;
          mc_io_d    = 1'b0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (owner == OWN_IF) begin
          if (flush_in) begin
            state_d = mc_back ? IDLE : DROP;
            owner_d = mc_back ? OWN_NONE : OWN_IF;
          end else if (mc_back) begin
            if_data_d = mc_back_ins;
            if_done_d = 1'b1;
            if_free   = 1'b1;
            state_d   = IDLE;
            owner_d   = OWN_NONE;
          end
        end else if (mc_res_avail) begin
          ls_rdata_d = ls_slot_store ? 32'd0 : mc_res;
          ls_done_d  = 1'b1;
          ls_free    = 1'b1;
          state_d    = IDLE;
          owner_d    = OWN_NONE;
        end
      end
      DROP: begin
        if (mc_back) begin
          state_d = IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase

    // A slot may refill on the same edge its previous request completes.
    if (flush_in || if_free)
      if_valid_d = 1'b0;
    if (if_req && !flush_in && !if_ack && (!if_valid || if_free)) begin
      if_valid_d     = 1'b1;
      if_slot_addr_d = if_addr;
      if_ack_d       = 1'b1;
    end
    if (ls_free)
      ls_valid_d = 1'b0;
    if (ls_req && !ls_ack && (!ls_valid || ls_free)) begin
      ls_valid_d      = 1'b1;
      ls_slot_store_d = ls_store;
      ls_slot_addr_d  = ls_addr;
      ls_slot_data_d  = ls_data;
      ls_slot_op_d    = ls_op;
      ls_ack_d        = 1'b1;
    end

    if (grant_if)
      starve_d = 3'd0;
    else if (grant_ls && if_avail && starve != 3'd7)
      starve_d = starve + 3'd1;
    if (!if_valid_d)
      starve_d = 3'd0;
  end

  // rdy_in low holds everything; one-cycle pulses simply end rather than repeat.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      owner         <= OWN_NONE;
      starve        <= 3'd0;
      if_valid      <= 1'b0;
      if_slot_addr  <= 32'd0;
      ls_valid      <= 1'b0;
      ls_slot_store <= 1'b0;
      ls_slot_addr  <= 32'd0;
      ls_slot_data  <= 32'd0;
      ls_slot_op    <= 3'd0;
      if_ack        <= 1'b0;
      if_done       <= 1'b0;
      if_data       <= 32'd0;
      ls_ack        <= 1'b0;
      ls_done       <= 1'b0;
      ls_rdata      <= 32'd0;
      mc_fetch      <= 1'b0;
      mc_fetch_addr <= 32'd0;
      mc_io         <= 1'b0;
      mc_store      <= 1'b0;
      mc_addr       <= 32'd0;
      mc_data       <= 32'd0;
      mc_op         <= 3'd0;
    end else if (rdy_in) begin
      state         <= state_d;
      owner         <= owner_d;
      starve        <= starve_d;
      if_valid      <= if_valid_d;
      if_slot_addr  <= if_slot_addr_d;
      ls_valid      <= ls_valid_d;
      ls_slot_store <= ls_slot_store_d;
      ls_slot_addr  <= ls_slot_addr_d;
      ls_slot_data  <= ls_slot_data_d;
      ls_slot_op    <= ls_slot_op_d;
      if_ack        <= if_ack_d;
      if_done       <= if_done_d;
      if_data       <= if_data_d;
      ls_ack        <= ls_ack_d;
      ls_done       <= ls_done_d;
      ls_rdata      <= ls_rdata_d;
      mc_fetch      <= mc_fetch_d;
      mc_fetch_addr <= mc_fetch_addr_d;
      mc_io         <= mc_io_d;
      mc_store      <= mc_store_d;
      mc_addr       <= mc_addr_d;
      mc_data       <= mc_data_d;
      mc_op         <= mc_op_d;
    end else begin
      if_ack  <= 1'b0;
      if_done <= 1'b0;
      ls_ack  <= 1'b0;
      ls_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle table for the basic LS/IF flow, then
// hand-written sequences for starvation, flush, rdy_in stall and mid-transaction reset.
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_in;
  logic        if_req, ls_req, ls_store;
  logic [31:0] if_addr, ls_addr, ls_data;
  logic [2:0]  ls_op;
  logic        mc_working, mc_back, mc_res_avail;
  logic [31:0] mc_back_ins, mc_res;
  logic        if_ack, if_done, ls_ack, ls_done;
  logic [31:0] if_data, ls_rdata;
  logic        mc_fetch, mc_io, mc_store;
  logic [31:0] mc_fetch_addr, mc_addr, mc_data;
  logic [2:0]  mc_op;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_store(ls_store), .ls_addr(ls_addr), .ls_data(ls_data), .ls_op(ls_op),
    .ls_ack(ls_ack), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mc_fetch(mc_fetch), .mc_fetch_addr(mc_fetch_addr), .mc_io(mc_io), .mc_store(mc_store),
    .mc_addr(mc_addr), .mc_data(mc_data), .mc_op(mc_op), .mc_working(mc_working),
    .mc_back(mc_back), .mc_back_ins(mc_back_ins), .mc_res_avail(mc_res_avail), .mc_res(mc_res)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rst, if_req, ls_req, flush, mcw, mcb, mcr;
    logic [31:0] if_addr, ls_addr, back_ins, res;
    logic [5:0]  exp_flags;
    logic [31:0] exp_if_data, exp_ls_rdata, exp_mc_addr, exp_fetch_addr;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic ireq, input logic lreq,
                              input logic fl, input logic mcw, input logic mcb, input logic mcr,
                              input logic [31:0] ia, input logic [31:0] la,
                              input logic [31:0] bi, input logic [31:0] rs,
                              input logic [5:0] ef, input logic [31:0] eid,
                              input logic [31:0] elr, input logic [31:0] ema,
                              input logic [31:0] efa);
    vec_t v;
    v.rst = rst; v.if_req = ireq; v.ls_req = lreq; v.flush = fl;
    v.mcw = mcw; v.mcb = mcb; v.mcr = mcr;
    v.if_addr = ia; v.ls_addr = la; v.back_ins = bi; v.res = rs;
    v.exp_flags = ef; v.exp_if_data = eid; v.exp_ls_rdata = elr;
    v.exp_mc_addr = ema; v.exp_fetch_addr = efa;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_in = v.rst; if_req = v.if_req; ls_req = v.ls_req; flush_in = v.flush;
    mc_working = v.mcw; mc_back = v.mcb; mc_res_avail = v.mcr;
    if_addr = v.if_addr; ls_addr = v.ls_addr; mc_back_ins = v.back_ins; mc_res = v.res;
    ls_store = 1'b0; ls_data = 32'd0; ls_op = 3'd0;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // kind: 1 = LS granted, 0 = fetch granted, 2 = nothing within the budget
  task automatic wait_grant(output int kind);
    int n = 0;
    kind = 2;
    do begin
      step();
      n++;
    end while (!mc_fetch && !mc_io && n < 10);
    if (mc_io) kind = 1;
    else if (mc_fetch) kind = 0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1; step(); rst_in = 1'b0;
  endtask

  always @(negedge clk_in)
    checkOutput("one_hot_req", {31'd0, mc_fetch & mc_io}, 32'd0);

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  vec_t vecs[11];
  int   kind;
  int   exp_order[7] = '{1, 1, 1, 1, 0, 1, 1};
  int   ls_issued, ls_served;
  logic raise;

  initial begin
    rdy_in = 1'b1;
    // {if_ack, if_done, ls_ack, ls_done, mc_fetch, mc_io}
    vecs[0]  = mk(1,0,0,0,0,0,0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0);
    vecs[1]  = mk(0,1,1,0,0,0,0, 32'h1000, 32'h20, 0, 0, 6'b101000, 0, 0, 0, 0);
    vecs[2]  = mk(0,0,0,0,0,0,0, 0, 0, 0, 0, 6'b000001, 0, 0, 32'h20, 0);
    vecs[3]  = mk(0,0,0,0,0,0,0, 0, 0, 0, 0, 6'b000001, 0, 0, 32'h20, 0);
    vecs[4]  = mk(0,0,0,0,1,0,0, 0, 0, 0, 0, 6'b000000, 0, 0, 32'h20, 0);
    vecs[5]  = mk(0,0,0,0,0,0,0, 0, 0, 0, 0, 6'b000000, 0, 0, 32'h20, 0);
    vecs[6]  = mk(0,0,0,0,0,0,1, 0, 0, 0, 32'hFFFFFF80, 6'b000100, 0, 32'hFFFFFF80, 32'h20, 0);
    vecs[7]  = mk(0,0,0,0,0,0,0, 0, 0, 0, 0, 6'b000010, 0, 32'hFFFFFF80, 32'h20, 32'h1000);
    vecs[8]  = mk(0,0,0,0,1,0,0, 0, 0, 0, 0, 6'b000000, 0, 32'hFFFFFF80, 32'h20, 32'h1000);
    vecs[9]  = mk(0,0,0,0,0,1,0, 0, 0, 32'h00A00093, 0, 6'b010000, 32'h00A00093, 32'hFFFFFF80, 32'h20, 32'h1000);
    vecs[10] = mk(0,0,0,0,0,0,0, 0, 0, 0, 0, 6'b000000, 32'h00A00093, 32'hFFFFFF80, 32'h20, 32'h1000);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput($sformatf("vec%0d_flags", i),
                  {26'd0, if_ack, if_done, ls_ack, ls_done, mc_fetch, mc_io}, {26'd0, vecs[i].exp_flags});
      checkOutput($sformatf("vec%0d_if_data", i), if_data, vecs[i].exp_if_data);
      checkOutput($sformatf("vec%0d_ls_rdata", i), ls_rdata, vecs[i].exp_ls_rdata);
      checkOutput($sformatf("vec%0d_mc_addr", i), mc_addr, vecs[i].exp_mc_addr);
      checkOutput($sformatf("vec%0d_fetch_addr", i), mc_fetch_addr, vecs[i].exp_fetch_addr);
    end

    // Starvation: fetch waits behind LS traffic until four LS grants have gone by.
    do_reset();
    if_req = 1'b1; if_addr = 32'h2000;
    ls_req = 1'b1; ls_addr = 32'h100; ls_store = 1'b0; ls_op = 3'b010;
    step();
    checkOutput("starve_if_ack", {31'd0, if_ack}, 32'd1);
    checkOutput("starve_ls_ack", {31'd0, ls_ack}, 32'd1);
    if_req = 1'b0; ls_req = 1'b0;
    ls_issued = 1; ls_served = 0;
    for (int g = 0; g < 7; g++) begin
      wait_grant(kind);
      checkOutput($sformatf("starve_grant%0d_kind", g), kind, exp_order[g]);
      if (kind == 2) break;
      if (kind == 1)
        checkOutput($sformatf("starve_grant%0d_addr", g), mc_addr, 32'h100 + 32'(4 * ls_served));
      else
        checkOutput("starve_fetch_addr", mc_fetch_addr, 32'h2000);
      mc_working = 1'b1; step(); mc_working = 1'b0;
      raise = (kind == 1) && (ls_issued < 6);
      if (raise) begin
        ls_req = 1'b1; ls_addr = 32'h100 + 32'(4 * ls_issued);
      end
      if (kind == 1) begin
        mc_res_avail = 1'b1; mc_res = 32'h500 + 32'(ls_served);
        step();
        checkOutput("starve_ls_done", {31'd0, ls_done}, 32'd1);
        checkOutput("starve_ls_rdata", ls_rdata, 32'h500 + 32'(ls_served));
        if (raise) begin
          checkOutput("starve_refill_ack", {31'd0, ls_ack}, 32'd1);
          ls_issued++;
        end
        ls_req = 1'b0; mc_res_avail = 1'b0; ls_served++;
      end else begin
        mc_back = 1'b1; mc_back_ins = 32'hCAFE0001;
        step();
        checkOutput("starve_if_done", {31'd0, if_done}, 32'd1);
        checkOutput("starve_if_data", if_data, 32'hCAFE0001);
        mc_back = 1'b0;
      end
    end

    // Flush during fetch WAIT: returned word dropped, LS store still completes.
    do_reset();
    if_req = 1'b1; if_addr = 32'h3000;
    step();
    checkOutput("flush_if_ack", {31'd0, if_ack}, 32'd1);
    if_req = 1'b0;
    wait_grant(kind);
    checkOutput("flush_grant_kind", kind, 0);
    mc_working = 1'b1; step(); mc_working = 1'b0;
    flush_in = 1'b1;
    ls_req = 1'b1; ls_store = 1'b1; ls_addr = 32'h40; ls_data = 32'h12345678; ls_op = 3'b010;
    step();
    checkOutput("flush_ls_ack", {31'd0, ls_ack}, 32'd1);
    flush_in = 1'b0; ls_req = 1'b0;
    step();
    checkOutput("flush_drop_no_io", {31'd0, mc_io}, 32'd0);
    mc_back = 1'b1; mc_back_ins = 32'hDEADBEEF;
    step();
    checkOutput("flush_no_if_done", {31'd0, if_done}, 32'd0);
    checkOutput("flush_if_data", if_data, 32'd0);
    mc_back = 1'b0;
    wait_grant(kind);
    checkOutput("flush_ls_grant_kind", kind, 1);
    checkOutput("flush_mc_store", {31'd0, mc_store}, 32'd1);
    checkOutput("flush_mc_data", mc_data, 32'h12345678);
    checkOutput("flush_mc_op", {29'd0, mc_op}, 32'd2);
    checkOutput("flush_mc_addr", mc_addr, 32'h40);
    mc_working = 1'b1; step(); mc_working = 1'b0;
    mc_res_avail = 1'b1; mc_res = 32'hAAAA5555;
    step();
    checkOutput("flush_store_done", {31'd0, ls_done}, 32'd1);
    checkOutput("flush_store_rdata", ls_rdata, 32'd0);
    mc_res_avail = 1'b0;

    // rdy_in low for three cycles during LS WAIT.
    ls_req = 1'b1; ls_store = 1'b0; ls_addr = 32'h60; ls_op = 3'b100;
    step();
    ls_req = 1'b0;
    wait_grant(kind);
    checkOutput("rdy_grant_kind", kind, 1);
    mc_working = 1'b1; step(); mc_working = 1'b0;
    rdy_in = 1'b0; mc_res_avail = 1'b1; mc_res = 32'h7F;
    for (int c = 0; c < 3; c++) begin
      step();
      checkOutput("rdy_low_no_done", {31'd0, ls_done}, 32'd0);
      checkOutput("rdy_low_mc_addr", mc_addr, 32'h60);
      checkOutput("rdy_low_mc_op", {29'd0, mc_op}, 32'd4);
    end
    rdy_in = 1'b1;
    step();
    checkOutput("rdy_done", {31'd0, ls_done}, 32'd1);
    checkOutput("rdy_rdata", ls_rdata, 32'h7F);
    mc_res_avail = 1'b0;
    step();
    checkOutput("rdy_done_pulse_end", {31'd0, ls_done}, 32'd0);

    // Reset during LS WAIT, then a coincident flush/fetch, then a normal fetch.
    ls_req = 1'b1; ls_store = 1'b1; ls_addr = 32'h80; ls_data = 32'h0000BEEF; ls_op = 3'b001;
    step();
    ls_req = 1'b0;
    wait_grant(kind);
    checkOutput("rst_grant_kind", kind, 1);
    mc_working = 1'b1; step(); mc_working = 1'b0;
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    checkOutput("rst_mc_req", {30'd0, mc_fetch, mc_io}, 32'd0);
    checkOutput("rst_mc_addr", mc_addr, 32'd0);
    checkOutput("rst_mc_data", mc_data, 32'd0);
    checkOutput("rst_mc_op_store", {28'd0, mc_op, mc_store}, 32'd0);
    checkOutput("rst_ls_rdata", ls_rdata, 32'd0);
    checkOutput("rst_pulses", {28'd0, if_ack, if_done, ls_ack, ls_done}, 32'd0);
    mc_res_avail = 1'b1; mc_res = 32'h1234;
    flush_in = 1'b1; if_req = 1'b1; if_addr = 32'h4000;
    step();
    checkOutput("rst_no_stale_done", {31'd0, ls_done}, 32'd0);
    checkOutput("flush_req_no_ack", {31'd0, if_ack}, 32'd0);
    mc_res_avail = 1'b0; flush_in = 1'b0;
    step();
    checkOutput("post_rst_if_ack", {31'd0, if_ack}, 32'd1);
    if_req = 1'b0;
    wait_grant(kind);
    checkOutput("post_rst_grant_kind", kind, 0);
    checkOutput("post_rst_fetch_addr", mc_fetch_addr, 32'h4000);
    mc_working = 1'b1; step(); mc_working = 1'b0;
    mc_back = 1'b1; mc_back_ins = 32'h00000013;
    step();
    checkOutput("post_rst_if_done", {31'd0, if_done}, 32'd1);
    checkOutput("post_rst_if_data", if_data, 32'h00000013);
    mc_back = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
